// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP32 datapath blocks (divider, multiplier).
// Provides field widths, bias, canonical special encodings, operand class
// decoding and the divider's state encoding.
package fp32_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int          EXP_BIAS = 127;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_RND
    } div_state_t;

    // Exponent field 0 is taken as zero: denormals are flushed.
    function automatic fp_class_t fp_classify(input logic [FP_W-1:0] x);
        fp_class_t c;
        if (x[FP_W-2 -: EXP_W] == '0)
            c = CLS_ZERO;
        else if (x[FP_W-2 -: EXP_W] == '1)
            c = (x[MANT_W-1:0] != '0) ? CLS_NAN : CLS_INF;
        else
            c = CLS_NORM;
        return c;
    endfunction

endpackage

// File: rtl/fp32_div_seq_if.sv
// Request/response bundle of the sequential FP32 divider.
//   start, FP_A, FP_B            : request side (driven by master)
//   busy, done, FP_out, div_by_zero : response side (driven by slave)
interface fp32_div_seq_if;
    import fp32_pkg::*;

    logic            start;
    logic [FP_W-1:0] FP_A;
    logic [FP_W-1:0] FP_B;
    logic            busy;
    logic            done;
    logic [FP_W-1:0] FP_out;
    logic            div_by_zero;

    modport master (
        output start, FP_A, FP_B,
        input  busy, done, FP_out, div_by_zero
    );

    modport slave (
        input  start, FP_A, FP_B,
        output busy, done, FP_out, div_by_zero
    );
endinterface

// File: rtl/fp32_mant_div_iter.sv
// Iterative restoring divider for 24-bit significands (hidden bit included).
// One quotient bit per clock after load; the first bit has weight 2^0, so the
// quotient of two normalised significands lies in (0.5, 2).
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture dividend/divisor and start iterating
//   dividend     : 24-bit significand of the numerator
//   divisor      : 24-bit significand of the denominator
//   quotient     : Q_BITS quotient bits, MSB first
//   rem_nonzero  : final partial remainder is nonzero (sticky source)
//   done         : high during the cycle whose closing edge performs the last iteration
module fp32_mant_div_iter #(
    parameter int unsigned Q_BITS = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [23:0]       dividend,
    input  logic [23:0]       divisor,
    output logic [Q_BITS-1:0] quotient,
    output logic              rem_nonzero,
    output logic              done
);
    localparam int unsigned CW = $clog2(Q_BITS);

    logic [24:0]   rem;
    logic [23:0]   dvs;
    logic [CW-1:0] cnt;
    logic          active;
    logic          ge;
    logic [24:0]   sub;

    always_comb begin
        ge  = (rem >= {1'b0, dvs});
        sub = rem - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            quotient <= '0;
        end else if (load) begin
            rem      <= {1'b0, dividend};
            dvs      <= divisor;
            cnt      <= '0;
            active   <= 1'b1;
            quotient <= '0;
        end else if (active) begin
            // Partial remainder stays below 2*divisor, so 25 bits never overflow.
            quotient <= {quotient[Q_BITS-2:0], ge};
            rem      <= (ge ? sub : rem) << 1;
            cnt      <= cnt + 1'b1;
            if (cnt == CW'(Q_BITS - 1))
                active <= 1'b0;
        end
    end

    // Combinational so the controller leaves its divide state on the same
    // edge that produces the last quotient bit.
    assign done        = active && (cnt == CW'(Q_BITS - 1));
    assign rem_nonzero = (rem != '0);

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 binary32 divider, FP_out = FP_A / FP_B.
// Fixed latency of LAT edges from acceptance to the done pulse for every
// operand class; special cases are decided at capture and delivered at the end.
// Round-to-nearest-even, denormal inputs flushed, underflow flushed to zero.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fp32_div_seq_if
//              (start, FP_A, FP_B in; busy, done, FP_out, div_by_zero out)
module fp32_div_seq
    import fp32_pkg::*;
#(
    parameter int unsigned Q_BITS = 26
) (
    input  logic          clk,
    input  logic          rst,
    fp32_div_seq_if.slave bus
);
    localparam int unsigned LAT = Q_BITS + 2;
    // Quotient bits below guard/round fold into sticky (none at the default width).
    localparam logic [Q_BITS-1:0] LOW_MASK = (Q_BITS'(1) << (Q_BITS - 26)) - Q_BITS'(1);

    div_state_t        state;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [Q_BITS-1:0] q_r;
    logic              spec_r;
    logic [FP_W-1:0]   spec_val_r;
    logic              spec_dbz_r;

    logic              load;
    logic [Q_BITS-1:0] mant_q;
    logic              mant_rem_nz;
    logic              mant_last;

    fp32_mant_div_iter #(
        .Q_BITS(LAT - 2)
    ) u_mant_div (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .dividend   ({1'b1, bus.FP_A[MANT_W-1:0]}),
        .divisor    ({1'b1, bus.FP_B[MANT_W-1:0]}),
        .quotient   (mant_q),
        .rem_nonzero(mant_rem_nz),
        .done       (mant_last)
    );

    assign load = (state == ST_IDLE) && bus.start;

    // Capture-time decode of operand classes into a special result.
    fp_class_t         cls_a, cls_b;
    logic              sign_cap;
    logic signed [9:0] exp_cap;
    logic              sp_hit;
    logic [FP_W-1:0]   sp_val;
    logic              sp_dbz;

    always_comb begin
        cls_a    = fp_classify(bus.FP_A);
        cls_b    = fp_classify(bus.FP_B);
        sign_cap = bus.FP_A[FP_W-1] ^ bus.FP_B[FP_W-1];
        exp_cap  = $signed({2'b00, bus.FP_A[FP_W-2 -: EXP_W]})
                 - $signed({2'b00, bus.FP_B[FP_W-2 -: EXP_W]})
                 + 10'(EXP_BIAS);
        sp_hit   = 1'b1;
        sp_val   = '0;
        sp_dbz   = 1'b0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN)
            sp_val = QNAN;
        else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_INF  && cls_b == CLS_INF))
            sp_val = QNAN;
        else if (cls_a == CLS_INF)
            sp_val = POS_INF | {sign_cap, 31'b0};
        else if (cls_b == CLS_ZERO) begin
            sp_val = POS_INF | {sign_cap, 31'b0};
            sp_dbz = 1'b1;
        end else if (cls_b == CLS_INF || cls_a == CLS_ZERO)
            sp_val = {sign_cap, 31'b0};
        else
            sp_hit = 1'b0;
    end

    // Round-to-nearest-even on the normalised quotient held in q_r.
    logic              lsb, guard, rnd, sticky, round_up;
    logic [24:0]       mant_sum;
    logic signed [9:0] exp_rnd;
    logic [FP_W-1:0]   result;

    always_comb begin
        lsb      = q_r[Q_BITS-24];
        guard    = q_r[Q_BITS-25];
        rnd      = q_r[Q_BITS-26];
        sticky   = mant_rem_nz | ((q_r & LOW_MASK) != '0);
        round_up = guard & (rnd | sticky | lsb);
        mant_sum = {1'b0, q_r[Q_BITS-1 -: 24]} + {24'b0, round_up};
        exp_rnd  = exp_r + (mant_sum[24] ? 10'sd1 : 10'sd0);
        if (exp_rnd >= 10'sd255)
            result = POS_INF | {sign_r, 31'b0};
        else if (exp_rnd <= 10'sd0)
            result = {sign_r, 31'b0};
        else if (mant_sum[24])
            result = {sign_r, exp_rnd[7:0], mant_sum[23:1]};
        else
            result = {sign_r, exp_rnd[7:0], mant_sum[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.FP_out      <= '0;
            bus.div_by_zero <= 1'b0;
            sign_r          <= 1'b0;
            exp_r           <= '0;
            q_r             <= '0;
            spec_r          <= 1'b0;
            spec_val_r      <= '0;
            spec_dbz_r      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bus.busy   <= 1'b1;
                        sign_r     <= sign_cap;
                        exp_r      <= exp_cap;
                        spec_r     <= sp_hit;
                        spec_val_r <= sp_val;
                        spec_dbz_r <= sp_dbz;
                        state      <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (mant_last)
                        state <= ST_NORM;
                end
                ST_NORM: begin
                    if (!mant_q[Q_BITS-1]) begin
                        q_r   <= mant_q << 1;
                        exp_r <= exp_r - 10'sd1;
                    end else begin
                        q_r <= mant_q;
                    end
                    state <= ST_RND;
                end
                ST_RND: begin
                    bus.FP_out      <= spec_r ? spec_val_r : result;
                    bus.div_by_zero <= spec_r & spec_dbz_r;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
